uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the 8N1 UART receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // 50 MHz system clock, 115200 baud
    localparam int c_DEFAULT_CLKS_PER_BIT = 434;

    // Data bits per frame and the width of an index into them
    localparam int c_FRAME_BITS = 8;
    localparam int c_BIT_IDX_W  = $clog2(c_FRAME_BITS);

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit, with a
//                configurable reset value so an idle-high line stays idle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability-settling chain; both stages load the reset value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Start bit is verified at mid-bit, data is
//                sampled once per bit period LSB first, a bad stop bit raises
//                frame_err and parks in BREAK until the line returns high.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_TIMER_W = $clog2(CLKS_PER_BIT);

    // Mid-start-bit sample point, end-of-bit sample point
    localparam logic [c_TIMER_W-1:0] c_HALF_LAST = c_TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TIMER_W-1:0] c_BIT_LAST  = c_TIMER_W'(CLKS_PER_BIT - 1);
    // Timer value a line transition is seen at when the sender runs at the
    // nominal rate; reloading it on every transition keeps the sample point
    // centred when the sender's bit period is a little off.
    localparam logic [c_TIMER_W-1:0] c_REALIGN   = c_TIMER_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
    localparam logic [c_BIT_IDX_W-1:0] c_LAST_IDX = c_BIT_IDX_W'(c_FRAME_BITS - 1);

    uart_state_t                r_state;
    uart_state_t                w_state_next;
    logic [c_TIMER_W-1:0]       r_timer;
    logic [c_TIMER_W-1:0]       w_timer_next;
    logic [c_BIT_IDX_W-1:0]     r_bit_idx;
    logic [c_BIT_IDX_W-1:0]     w_bit_idx_next;
    logic [c_FRAME_BITS-1:0]    r_shift;
    logic [c_FRAME_BITS-1:0]    w_shift_next;
    logic [c_FRAME_BITS-1:0]    r_rx_data;
    logic [c_FRAME_BITS-1:0]    w_rx_data_next;
    logic                       r_rx_valid;
    logic                       w_rx_valid_next;
    logic                       r_frame_err;
    logic                       w_frame_err_next;
    logic                       r_rx_prev;
    logic                       w_rx_sync;
    logic                       w_rx_edge;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_sync)
    );

    assign w_rx_edge = w_rx_sync ^ r_rx_prev;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_prev   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_frame_err <= w_frame_err_next;
            r_rx_prev   <= w_rx_sync;
        end
    end

    // Next-state, bit timing, shift and output pulse logic
    always_comb begin
        w_state_next     = r_state;
        w_timer_next     = r_timer;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_sync) begin
                    w_state_next = ST_START;
                    w_timer_next = '0;
                end
            end

            ST_START: begin
                if (r_timer == c_HALF_LAST) begin
                    if (!w_rx_sync) begin
                        w_state_next   = ST_DATA;
                        w_timer_next   = '0;
                        w_bit_idx_next = '0;
                    end else begin
                        // Line went back high: noise, not a start bit
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            ST_DATA: begin
                if (r_timer == c_BIT_LAST) begin
                    w_shift_next = {w_rx_sync, r_shift[c_FRAME_BITS-1:1]};
                    w_timer_next = '0;
                    if (r_bit_idx == c_LAST_IDX) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end else if (w_rx_edge) begin
                    w_timer_next = c_REALIGN;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            ST_STOP: begin
                if (r_timer == c_BIT_LAST) begin
                    w_timer_next = '0;
                    if (w_rx_sync) begin
                        w_rx_data_next  = r_shift;
                        w_rx_valid_next = 1'b1;
                        w_state_next    = ST_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = ST_BREAK;
                    end
                end else if (w_rx_edge) begin
                    w_timer_next = c_REALIGN;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            ST_BREAK: begin
                // Ignore the low line until it is released
                if (w_rx_sync) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx at 16 clocks per bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Monitor state (written only by the monitor)
    int         cyc            = 0;
    int         mon_valid_cnt  = 0;
    int         mon_ferr_cnt   = 0;
    int         mon_busy_cnt   = 0;
    int         mon_overlap    = 0;
    int         mon_hold_viol  = 0;
    int         mon_valid_cyc  = 0;
    logic [7:0] mon_prev_data  = 8'h00;
    logic [7:0] mon_data [0:63];

    int fall_cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         period;
        int         stop_len;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    uart_rx #(
        .CLKS_PER_BIT (c_CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            mon_prev_data <= rx_data;
        end else begin
            if (rx_valid) begin
                if (mon_valid_cnt < 64) mon_data[mon_valid_cnt] <= rx_data;
                mon_valid_cnt <= mon_valid_cnt + 1;
                mon_valid_cyc <= cyc;
            end
            if (frame_err) mon_ferr_cnt <= mon_ferr_cnt + 1;
            if (rx_valid && frame_err) mon_overlap <= mon_overlap + 1;
            if (!rx_valid && (rx_data !== mon_prev_data)) mon_hold_viol <= mon_hold_viol + 1;
            if (busy) mon_busy_cnt <= mon_busy_cnt + 1;
            mon_prev_data <= rx_data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // All drives happen on falling edges
    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int per, input int stop_len);
        fall_cyc = cyc;
        drive_bit(1'b0, per);
        for (int b = 0; b < 8; b++) drive_bit(d[b], per);
        drive_bit(stop, stop_len);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, b0;

        vecs[0] = '{8'h35, 1'b1, 16, 16, 1, 0, 8'h35};
        vecs[1] = '{8'h00, 1'b1, 16, 16, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 16, 16, 1, 0, 8'hFF};
        vecs[3] = '{8'h30, 1'b1, 15, 15, 1, 0, 8'h30};
        vecs[4] = '{8'h30, 1'b1, 17, 17, 1, 0, 8'h30};
        vecs[5] = '{8'h81, 1'b1, 16, 16, 1, 0, 8'h81};
        vecs[6] = '{8'h5A, 1'b0, 16, 16, 0, 1, 8'h81};

        rx    = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset rx_data", int'(rx_data), 8'h00);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset busy", int'(busy), 0);
        reset = 1'b0;
        idle(8);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            v0 = mon_valid_cnt;
            f0 = mon_ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].period, vecs[i].stop_len);
            idle(3 * c_CPB);
            check($sformatf("vec%0d valid count", i), mon_valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d ferr count", i), mon_ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d busy idle", i), int'(busy), 0);
        end

        // Short glitch on the line is rejected
        v0 = mon_valid_cnt;
        f0 = mon_ferr_cnt;
        b0 = mon_busy_cnt;
        drive_bit(1'b0, 4);
        idle(40);
        check_range("glitch busy cycles", mon_busy_cnt - b0, 1, 9);
        check("glitch valid count", mon_valid_cnt - v0, 0);
        check("glitch ferr count", mon_ferr_cnt - f0, 0);

        // 0x35, latency, then bad stop bit with a long break, then 0x32
        v0 = mon_valid_cnt;
        f0 = mon_ferr_cnt;
        send_frame(8'h35, 1'b1, c_CPB, c_CPB);
        idle(3 * c_CPB);
        check("0x35 valid count", mon_valid_cnt - v0, 1);
        check("0x35 rx_data", int'(rx_data), 8'h35);
        check("0x35 ferr count", mon_ferr_cnt - f0, 0);
        check_range("0x35 latency", mon_valid_cyc - fall_cyc, 153, 155);

        v0 = mon_valid_cnt;
        f0 = mon_ferr_cnt;
        send_frame(8'hA5, 1'b0, c_CPB, 40);
        idle(3 * c_CPB);
        check("break ferr count", mon_ferr_cnt - f0, 1);
        check("break valid count", mon_valid_cnt - v0, 0);
        check("break rx_data held", int'(rx_data), 8'h35);

        v0 = mon_valid_cnt;
        send_frame(8'h32, 1'b1, c_CPB, c_CPB);
        idle(3 * c_CPB);
        check("after break valid count", mon_valid_cnt - v0, 1);
        check("after break rx_data", int'(rx_data), 8'h32);

        // Back-to-back "12\n" with no idle gap
        v0 = mon_valid_cnt;
        send_frame(8'h31, 1'b1, c_CPB, c_CPB);
        send_frame(8'h32, 1'b1, c_CPB, c_CPB);
        send_frame(8'h0A, 1'b1, c_CPB, c_CPB);
        idle(3 * c_CPB);
        check("b2b valid count", mon_valid_cnt - v0, 3);
        check("b2b byte0", int'(mon_data[v0]), 8'h31);
        check("b2b byte1", int'(mon_data[v0 + 1]), 8'h32);
        check("b2b byte2", int'(mon_data[v0 + 2]), 8'h0A);

        // Reset in the middle of data bit 3, then a clean frame
        v0 = mon_valid_cnt;
        f0 = mon_ferr_cnt;
        drive_bit(1'b0, c_CPB);
        for (int b = 0; b < 3; b++) drive_bit(1'b0, c_CPB);
        drive_bit(1'b0, c_CPB / 2);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset busy", int'(busy), 0);
        check("midreset rx_data", int'(rx_data), 8'h00);
        reset = 1'b0;
        idle(40);
        check("midreset valid count", mon_valid_cnt - v0, 0);
        check("midreset ferr count", mon_ferr_cnt - f0, 0);
        send_frame(8'h39, 1'b1, c_CPB, c_CPB);
        idle(3 * c_CPB);
        check("post-reset valid count", mon_valid_cnt - v0, 1);
        check("post-reset rx_data", int'(rx_data), 8'h39);

        // Whole-run properties
        check("valid/ferr overlap cycles", mon_overlap, 0);
        check("rx_data changes without valid", mon_hold_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
